// File: rtl/alu_script.sv
// Single-operation execution unit for the Bitcoin-script processor: takes one or
// two popped stack items plus an opcode and returns 0..2 items to push.
module alu_script #(
  parameter int DATA_W = 512,
  parameter int MSG_W  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        opcode,
  input  logic              put_alu_in1,
  input  logic [DATA_W-1:0] data_alu_in1,
  input  logic              put_alu_in2,
  input  logic [DATA_W-1:0] data_alu_in2,
  input  logic [MSG_W-1:0]  check_sig_msg,
  output logic              pop_req,
  output logic              put_alu_out1,
  output logic              put_alu_out2,
  output logic [DATA_W-1:0] data_alu_out1,
  output logic [DATA_W-1:0] data_alu_out2,
  output logic              done,
  output logic              error
);

  typedef enum logic [1:0] {IDLE, FETCH2, EXEC, RESP} state_t;

  localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

  state_t            state_q, state_d;
  logic [7:0]        op_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic [DATA_W-1:0] res1_q, res1_d, res2_q, res2_d;
  logic              rp1_q, rp1_d, rp2_q, rp2_d, ok_q, ok_d;
  logic [DATA_W-1:0] out1_q, out2_q;
  logic              put1_q, put2_q, done_q, error_q;

  function automatic logic twoOps(input logic [7:0] op);
    case (op)
      8'h7c, 8'h87, 8'h88, 8'h93, 8'h94, 8'hac: twoOps = 1'b1;
      default:                                  twoOps = 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (put_alu_in1) begin
          if (twoOps(opcode) && !put_alu_in2) state_d = FETCH2;
          else                                state_d = EXEC;
        end
      end
      FETCH2:  if (put_alu_in2) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture: a is the deeper item, b the former stack top.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
    end else if (state_q == IDLE && put_alu_in1) begin
      op_q <= opcode;
      b_q  <= data_alu_in1;
      if (twoOps(opcode) && put_alu_in2) a_q <= data_alu_in2;
    end else if (state_q == FETCH2 && put_alu_in2) begin
      a_q <= data_alu_in2;
    end
  end

  always_comb begin
    res1_d = '0;
    res2_d = '0;
    rp1_d  = 1'b0;
    rp2_d  = 1'b0;
    ok_d   = 1'b1;
    case (op_q)
      8'h69: ok_d = |b_q;
      8'h75: ok_d = 1'b1;
      8'h76: begin res1_d = b_q; res2_d = b_q; rp1_d = 1'b1; rp2_d = 1'b1; end
      8'h7c: begin res1_d = b_q; res2_d = a_q; rp1_d = 1'b1; rp2_d = 1'b1; end
      8'h87: begin res1_d = DATA_W'(a_q == b_q); rp1_d = 1'b1; end
      8'h88: ok_d = (a_q == b_q);
      8'h8b: begin res1_d = b_q + ONE; rp1_d = 1'b1; end
      8'h8c: begin res1_d = b_q - ONE; rp1_d = 1'b1; end
      8'h91: begin res1_d = DATA_W'(b_q == '0); rp1_d = 1'b1; end
      8'h93: begin res1_d = a_q + b_q; rp1_d = 1'b1; end
      8'h94: begin res1_d = a_q - b_q; rp1_d = 1'b1; end
      // Simplified signature check: XOR of signature and pubkey compared to the digest.
      8'hac: begin
        res1_d = DATA_W'((a_q[MSG_W-1:0] ^ b_q[MSG_W-1:0]) == check_sig_msg);
        rp1_d  = 1'b1;
      end
      default: ok_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res1_q <= '0;
      res2_q <= '0;
      rp1_q  <= 1'b0;
      rp2_q  <= 1'b0;
      ok_q   <= 1'b0;
    end else if (state_q == EXEC) begin
      res1_q <= res1_d;
      res2_q <= res2_d;
      rp1_q  <= rp1_d;
      rp2_q  <= rp2_d;
      ok_q   <= ok_d;
    end
  end

  // Response registers pulse for one cycle; data buses keep their last pushed value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out1_q  <= '0;
      out2_q  <= '0;
      put1_q  <= 1'b0;
      put2_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      put1_q  <= 1'b0;
      put2_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      if (state_q == RESP) begin
        if (ok_q) begin
          done_q <= 1'b1;
          put1_q <= rp1_q;
          put2_q <= rp2_q;
          if (rp1_q) out1_q <= res1_q;
          if (rp2_q) out2_q <= res2_q;
        end else begin
          error_q <= 1'b1;
        end
      end
    end
  end

  assign pop_req       = (state_q == FETCH2);
  assign put_alu_out1  = put1_q;
  assign put_alu_out2  = put2_q;
  assign data_alu_out1 = out1_q;
  assign data_alu_out2 = out2_q;
  assign done          = done_q;
  assign error         = error_q;

endmodule

// File: tb/tb_alu_script.sv
// Scoreboard bench for alu_script: random and directed operations checked
// against a behavioural model of the opcode rules.
module tb_alu_script;

  localparam int DATA_W = 512;
  localparam int MSG_W  = 256;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        opcode;
  logic              put_alu_in1, put_alu_in2;
  logic [DATA_W-1:0] data_alu_in1, data_alu_in2;
  logic [MSG_W-1:0]  check_sig_msg;
  logic              pop_req, put_alu_out1, put_alu_out2, done, error;
  logic [DATA_W-1:0] data_alu_out1, data_alu_out2;

  alu_script #(.DATA_W(DATA_W), .MSG_W(MSG_W)) dut (
    .clk(clk), .rst(rst), .opcode(opcode),
    .put_alu_in1(put_alu_in1), .data_alu_in1(data_alu_in1),
    .put_alu_in2(put_alu_in2), .data_alu_in2(data_alu_in2),
    .check_sig_msg(check_sig_msg), .pop_req(pop_req),
    .put_alu_out1(put_alu_out1), .put_alu_out2(put_alu_out2),
    .data_alu_out1(data_alu_out1), .data_alu_out2(data_alu_out2),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              isErr;
    logic              p1;
    logic              p2;
    logic [DATA_W-1:0] d1;
    logic [DATA_W-1:0] d2;
    int                cyc;
    logic [7:0]        op;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cycle = 0;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [DATA_W-1:0] rand512();
    logic [DATA_W-1:0] v;
    for (int i = 0; i < DATA_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic bit needsTwo(input logic [7:0] op);
    return op == 8'h7c || op == 8'h87 || op == 8'h88 || op == 8'h93 ||
           op == 8'h94 || op == 8'hac;
  endfunction

  // Opcode rules with a = deeper item, b = top item.
  function automatic exp_t model(input logic [7:0] op, input logic [DATA_W-1:0] a,
                                 input logic [DATA_W-1:0] b, input logic [MSG_W-1:0] msg);
    exp_t r;
    r.isErr = 0; r.p1 = 0; r.p2 = 0; r.d1 = 0; r.d2 = 0; r.cyc = 0; r.op = op;
    case (op)
      8'h69: r.isErr = (b == 0);
      8'h75: ;
      8'h76: begin r.p1 = 1; r.p2 = 1; r.d1 = b; r.d2 = b; end
      8'h7c: begin r.p1 = 1; r.p2 = 1; r.d1 = b; r.d2 = a; end
      8'h87: begin r.p1 = 1; r.d1 = (a == b) ? 1 : 0; end
      8'h88: r.isErr = (a != b);
      8'h8b: begin r.p1 = 1; r.d1 = b + 1; end
      8'h8c: begin r.p1 = 1; r.d1 = b - 1; end
      8'h91: begin r.p1 = 1; r.d1 = (b == 0) ? 1 : 0; end
      8'h93: begin r.p1 = 1; r.d1 = a + b; end
      8'h94: begin r.p1 = 1; r.d1 = a - b; end
      8'hac: begin r.p1 = 1; r.d1 = ((a[MSG_W-1:0] ^ b[MSG_W-1:0]) == msg) ? 1 : 0; end
      default: r.isErr = 1;
    endcase
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [DATA_W-1:0] act,
                             input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every response pulse must match the oldest scoreboard entry.
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (done || error) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_response", {done, error}, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("resp_cycle", cycle, e.cyc);
          checkOutput("done", done, !e.isErr);
          checkOutput("error", error, e.isErr);
          checkOutput("put_out1", put_alu_out1, e.p1);
          checkOutput("put_out2", put_alu_out2, e.p2);
          if (e.p1) checkOutput("data_out1", data_alu_out1, e.d1);
          if (e.p2) checkOutput("data_out2", data_alu_out2, e.d2);
        end
      end else begin
        checkOutput("idle_puts", {put_alu_out1, put_alu_out2}, 0);
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] op, input logic [DATA_W-1:0] b,
                               input logic [DATA_W-1:0] a, input bit in2Now, input int delay);
    exp_t e;
    int   latchEdge;
    opcode       = op;
    data_alu_in1 = b;
    put_alu_in1  = 1;
    data_alu_in2 = a;
    put_alu_in2  = in2Now;
    @(negedge clk);
    latchEdge   = cycle;
    put_alu_in1 = 0;
    put_alu_in2 = 0;
    data_alu_in1 = rand512();
    if (needsTwo(op) && !in2Now) begin
      data_alu_in2 = rand512();
      checkOutput("pop_req_high", pop_req, 1);
      repeat (delay) @(negedge clk);
      data_alu_in2 = a;
      put_alu_in2  = 1;
      @(negedge clk);
      latchEdge   = cycle;
      put_alu_in2 = 0;
      data_alu_in2 = rand512();
    end
    checkOutput("pop_req_low", pop_req, 0);
    e = model(op, a, b, check_sig_msg);
    e.cyc = latchEdge + 2;
    sb.push_back(e);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0) break;
    end
    if (sb.size() != 0) begin
      checkOutput("response_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  logic [7:0] opList [12];
  initial begin
    opList = '{8'h69, 8'h75, 8'h76, 8'h7c, 8'h87, 8'h88,
               8'h8b, 8'h8c, 8'h91, 8'h93, 8'h94, 8'hac};
  end

  initial begin
    logic [DATA_W-1:0] a, b;
    logic [7:0]        op;
    rst = 1; opcode = 0; put_alu_in1 = 0; put_alu_in2 = 0;
    data_alu_in1 = 0; data_alu_in2 = 0;
    check_sig_msg = rand512()[MSG_W-1:0];
    repeat (2) @(negedge clk);
    checkOutput("rst_pop_req", pop_req, 0);
    checkOutput("rst_done_error", {done, error}, 0);
    checkOutput("rst_puts", {put_alu_out1, put_alu_out2}, 0);
    checkOutput("rst_data1", data_alu_out1, 0);
    checkOutput("rst_data2", data_alu_out2, 0);
    rst = 0;
    @(negedge clk);

    applyStimulus(8'h76, 512'hDEADBEEF, 0, 0, 0);
    applyStimulus(8'h76, 512'hDEADBEEF, 0, 1, 0);
    applyStimulus(8'h93, 5, 7, 0, 2);
    applyStimulus(8'h94, 3, 10, 1, 0);
    applyStimulus(8'h7c, 3, 10, 1, 0);
    applyStimulus(8'h88, 8'h55, 8'h55, 1, 0);
    applyStimulus(8'h88, 8'h56, 8'h55, 0, 1);
    applyStimulus(8'hFF, 1, 1, 1, 0);
    applyStimulus(8'h69, 0, 0, 0, 0);
    applyStimulus(8'h91, 0, 0, 0, 0);
    applyStimulus(8'h8c, 0, 0, 0, 0);
    applyStimulus(8'h8b, {DATA_W{1'b1}}, 0, 0, 0);
    a = rand512();
    b = rand512();
    b[MSG_W-1:0] = a[MSG_W-1:0] ^ check_sig_msg;
    applyStimulus(8'hac, b, a, 1, 0);

    // Abort an ADD while it waits for its second operand.
    opcode = 8'h93; data_alu_in1 = 5; put_alu_in1 = 1; put_alu_in2 = 0;
    @(negedge clk);
    put_alu_in1 = 0;
    checkOutput("fetch2_pop_req", pop_req, 1);
    rst = 1;
    #1;
    checkOutput("abort_pop_req", pop_req, 0);
    checkOutput("abort_done_error", {done, error}, 0);
    checkOutput("abort_puts", {put_alu_out1, put_alu_out2}, 0);
    checkOutput("abort_data1", data_alu_out1, 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    applyStimulus(8'h93, 5, 7, 1, 0);

    for (int n = 0; n < 80; n++) begin
      op = ($urandom_range(0, 9) == 0) ? 8'($urandom) : opList[$urandom_range(0, 11)];
      case ($urandom_range(0, 3))
        0: begin a = 8'($urandom); b = 8'($urandom_range(0, 2)); end
        1: begin a = rand512(); b = a; end
        2: begin a = 0; b = rand512(); end
        default: begin a = rand512(); b = rand512(); end
      endcase
      applyStimulus(op, b, a, 1'($urandom), $urandom_range(0, 3));
    end

    checkOutput("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
